vnlp_list_sequencer: RTL

Sequences the VNLP linked-list datapath through a whole list walk. On `start` it issues the memory reads for each node's X/Y word and link word, pulses the datapath load strobes, and counts nodes. It stops on a null link, or flags an error when a length limit is hit. It sits between the host start/done handshake and the shared memory request port, replacing free-running fetch sequencing with an explicit request/grant/valid protocol.

---
 rtl/vnlp_pkg.sv | 18 +
 rtl/vnlp_list_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/vnlp_pkg.sv
// Shared types and constants for the VNLP linked-list sequencer.
package vnlp_pkg;

  localparam int VNLP_AW   = 8;
  localparam int VNLP_LW   = 8;
  localparam int NULL_LINK = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_XY,
    S_WT_XY,
    S_RD_LNK,
    S_WT_LNK,
    S_DONE,
    S_ERR
  } vnlp_state_e;

endpackage

// File: rtl/vnlp_list_sequencer.sv
// Walks a linked list node by node over a request/grant/valid memory port,
// strobing the datapath loads and counting nodes until a null link or MAX_LEN.
module vnlp_list_sequencer
  import vnlp_pkg::*;
#(
  parameter int AW      = VNLP_AW,
  parameter int LW      = VNLP_LW,
  parameter int MAX_LEN = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] head_addr,
  output logic          busy,
  output logic          done,
  output logic          err_len,
  output logic [LW-1:0] length,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [AW-1:0] mem_rdata,
  output logic          load_xy,
  output logic          load_link
);

  vnlp_state_e   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] len_q, len_d;
  logic          busy_q, done_q, err_q, req_q;
  logic [AW-1:0] addr_q;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    load_xy   = 1'b0;
    load_link = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          ptr_d   = head_addr;
          len_d   = '0;
          state_d = (head_addr == AW'(NULL_LINK)) ? S_DONE : S_RD_XY;
        end
      end
      S_RD_XY:  if (mem_gnt) state_d = S_WT_XY;
      S_WT_XY: begin
        if (mem_rvalid) begin
          load_xy = 1'b1;
          state_d = S_RD_LNK;
        end
      end
      S_RD_LNK: if (mem_gnt) state_d = S_WT_LNK;
      S_WT_LNK: begin
        if (mem_rvalid) begin
          load_link = 1'b1;
          len_d     = len_q + LW'(1);
          ptr_d     = mem_rdata;
          // A null link takes priority over hitting the length limit.
          if (mem_rdata == AW'(NULL_LINK))  state_d = S_DONE;
          else if (len_d == LW'(MAX_LEN))   state_d = S_ERR;
          else                              state_d = S_RD_XY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      // Outputs are registered from next state so they align with state_q.
      busy_q  <= (state_d == S_RD_XY) || (state_d == S_WT_XY) ||
                 (state_d == S_RD_LNK) || (state_d == S_WT_LNK);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
      req_q   <= (state_d == S_RD_XY) || (state_d == S_RD_LNK);
      addr_q  <= (state_d == S_RD_LNK) ? ptr_d + AW'(1) : ptr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err_len  = err_q;
  assign length   = len_q;
  assign mem_req  = req_q;
  assign mem_addr = addr_q;

endmodule
